serial_adder_16b: RTL
=====================

SERIAL_ADDER_16B -- requirements
Module: serial_adder_16b

Interface
REQ-001 SHALL have parameter WIDTH, default 16; it sets the operand width in bits, and 2 <= WIDTH <= 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 SHALL have port sum, output, WIDTH bits: result of a+b+cin, mod 2^WIDTH.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-012 SHALL have port ofl, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 SHALL compute exactly one result bit per clock, LSB first, using one instance of the team's fullAdder_1b cell plus a carry flip-flop; no WIDTH-bit adder is permitted.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL accept start at a rising edge in IDLE or DONE: load a, b, cin into the shift/carry registers, clear the bit counter to 0, go to RUN.
REQ-016 SHALL, in RUN, process bit[count] at each edge: sum bit = a^b^carry, carry <= majority(a, b, carry); then shift the operand registers right and increment the counter.
REQ-017 SHALL go from RUN to DONE on the edge that processes bit WIDTH-1; the counter does not wrap.
REQ-018 SHALL make latency fixed: done=1 in the cycle beginning WIDTH edges after the accepting edge (16 for the default WIDTH).
REQ-019 SHALL assert done only in DONE, for exactly one cycle; the next edge goes to RUN if start=1, otherwise to IDLE.
REQ-020 SHALL ignore start in RUN: no reload, no restart, no effect on the result.
REQ-021 SHALL hold sum, cout and ofl stable from DONE until the next accepted start; during RUN, sum is don't-care to consumers, but cout and ofl hold their previous values.
REQ-022 SHALL set cout to the final carry and ofl to (carry into MSB) XOR (carry out of MSB), both latched on the RUN-to-DONE edge.
REQ-023 SHALL set busy=1 in RUN only, and never assert busy and done together.
REQ-024 SHALL have no combinational path from start, a, b or cin to any output.

Reset
REQ-025 SHALL, on rst=1, immediately force state IDLE, counter 0, carry 0, busy 0, done 0, sum 0, cout 0 and ofl 0, independent of clk.
REQ-026 SHALL abandon an in-flight operation on reset mid-RUN, with no done pulse for it; operation resumes only after rst falls and a new start is accepted.
REQ-027 SHALL accept no start while rst=1.

Verification (WIDTH=16)
REQ-028 SHALL check: a=0xFFFF, b=0x0001, cin=0, start pulse -> done exactly 16 cycles later, sum=0x0000, cout=1, ofl=0.
REQ-029 SHALL check: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ofl=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ofl=1.
REQ-030 SHALL check: a=0x1234, b=0x4321, cin=1 with start held high through RUN and changing a/b mid-RUN -> sum=0x5556, cout=0, ofl=0, exactly one done pulse, then an immediate restart from DONE.
REQ-031 SHALL check: rst asserted after 7 RUN cycles -> busy=0, sum=0 with no clock edge; no done follows; the next start computes correctly.
REQ-032 SHALL check: 2000 random a/b/cin with random start gaps -> {cout,sum} equals a+b+cin and ofl matches the signed reference every time; busy/done exclusivity is checked each cycle.

Source files
------------

// File: rtl/serial_adder_16b.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock,
// LSB first, through a single full-adder cell and a carry flip-flop.

module fullAdder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;

  logic fa_s;
  logic fa_cout;
  logic last_bit;

  fullAdder_1b u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ofl_d   = ofl_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (last_bit) begin
          cout_d  = fa_cout;
          ofl_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
    end
  end

  // All outputs decode registered state only.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ofl  = ofl_q;

endmodule
